// File: rtl/packet_source_device_pkg.sv
// Shared types and register map for the inbound packet source block.
// Contents:
//   regAddr_e    byte offsets of the CPU-visible registers. The outbound
//                packet block uses the same offsets.
//   fifoEntry_t  one queued word: source channel, end-of-packet flag, payload.
//   ENTRY_W      width of fifoEntry_t in bits.
package packet_source_device_pkg;

  typedef enum logic [7:0] {
    REG_DATA_LO = 8'h04,
    REG_DATA_HI = 8'h08,
    REG_END     = 8'h0C,
    REG_STATUS  = 8'h10,
    REG_POP     = 8'h14,
    REG_ENABLE  = 8'h18,
    REG_DROP    = 8'h1C
  } regAddr_e;

  typedef struct packed {
    logic [7:0]  chan;
    logic        last;
    logic [63:0] data;
  } fifoEntry_t;

  localparam int ENTRY_W = $bits(fifoEntry_t);

endpackage

// File: rtl/packet_source_device_fifo.sv
// packet_fifo: synchronous FIFO. Its pointer and count state is cleared by
// an asynchronous active-low reset.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push, wdata  write request and data. Ignored while the FIFO is full.
//   pop          read request. Ignored while the FIFO is empty.
//   rdata        head entry. The value is stale while the FIFO is empty.
//   full, empty  occupancy flags
//   count        number of stored entries, 0..DEPTH
module packet_fifo #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             pushEff, popEff;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = storage[rdPtr_q];
  assign pushEff = push && !full;
  assign popEff  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushEff) wrPtr_d = wrPtr_q + 1'b1;
    if (popEff)  rdPtr_d = rdPtr_q + 1'b1;
    if (pushEff && !popEff)      count_d = count_q + 1'b1;
    else if (popEff && !pushEff) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // The storage array has no reset. Entries are only visible through count.
  always_ff @(posedge clk) begin
    if (pushEff) storage[wrPtr_q] <= wdata;
  end

endmodule

// File: rtl/packet_source_device.sv
// packet_source_device: merges CHANNELS producer streams into a tagged FIFO.
// The CPU reads and pops the FIFO head over the memory bus.
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   mem_req/we/addr/wdata   bus request. Reads return mem_rdata one cycle later.
//   mem_rdata               registered read data. It is 0 when no read was issued.
//   in_valid/in_data/in_end producer words, 64 bits per channel
//   in_ready                one-hot grant, combinational
//   irq                     level interrupt, high while the FIFO holds entries
module packet_source_device
  import packet_source_device_pkg::*;
#(
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_req,
  input  logic                     mem_we,
  input  logic [7:0]               mem_addr,
  input  logic [31:0]              mem_wdata,
  output logic [31:0]              mem_rdata,
  input  logic [CHANNELS-1:0]      in_valid,
  output logic [CHANNELS-1:0]      in_ready,
  input  logic [64*CHANNELS-1:0]   in_data,
  input  logic [CHANNELS-1:0]      in_end,
  output logic                     irq
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]       rrPtr_q, rrPtr_d;
  logic [CHANNELS-1:0] enable_q, enable_d;
  logic [31:0]         drop_q, drop_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                irq_q, irq_d;

  logic                full, empty;
  logic [AW:0]         count;
  fifoEntry_t          pushEntry, headEntry;
  logic                push, pop, popReq, enableWr, grantValid;
  logic [CW-1:0]       grantIdx;
  logic [CHANNELS-1:0] eligible;
  int                  cand;
  logic                unusedWdata;

  assign unusedWdata = ^mem_wdata;

  packet_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (pushEntry),
    .pop   (pop),
    .rdata (headEntry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Round-robin search from rrPtr_q. A full FIFO blocks the grant for the
  // whole cycle, even when a pop frees a slot, because pop and push do not
  // bypass each other. The grant is also blocked while reset is asserted, so
  // in_ready drops as soon as rst_n goes low.
  always_comb begin
    eligible   = in_valid & enable_q;
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = int'(rrPtr_q) + i;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      if (!grantValid && eligible[CW'(cand)]) begin
        grantValid = 1'b1;
        grantIdx   = CW'(cand);
      end
    end
    if (full || !rst_n) grantValid = 1'b0;
  end

  always_comb begin
    in_ready = '0;
    if (grantValid) in_ready[grantIdx] = 1'b1;
  end

  assign push           = grantValid;
  assign pushEntry.chan = 8'(grantIdx);
  assign pushEntry.last = in_end[grantIdx];
  assign pushEntry.data = in_data[int'(grantIdx)*64 +: 64];

  assign popReq   = mem_req && mem_we && (mem_addr == REG_POP);
  assign enableWr = mem_req && mem_we && (mem_addr == REG_ENABLE);
  assign pop      = popReq && !empty;

  // The interrupt is registered from the next occupancy, so it rises or falls
  // on the same edge that commits a push or pop.
  always_comb begin
    rrPtr_d  = rrPtr_q;
    enable_d = enable_q;
    drop_d   = drop_q;
    if (push) rrPtr_d = (int'(grantIdx) == CHANNELS-1) ? '0 : grantIdx + 1'b1;
    if (enableWr) enable_d = CHANNELS'(mem_wdata);
    if (popReq && empty && (drop_q != '1)) drop_d = drop_q + 1'b1;
    irq_d = push || (!empty && !(pop && count == (AW+1)'(1)));
  end

  // Read mux. Head fields read as zero while the FIFO is empty.
  always_comb begin
    rdata_d = '0;
    if (mem_req && !mem_we) begin
      case (mem_addr)
        REG_DATA_LO: if (!empty) rdata_d = headEntry.data[31:0];
        REG_DATA_HI: if (!empty) rdata_d = headEntry.data[63:32];
        REG_END:     if (!empty) rdata_d = {31'b0, headEntry.last};
        REG_STATUS:  rdata_d = {16'(count), (empty ? 8'h00 : headEntry.chan),
                                7'b0, !empty};
        REG_ENABLE:  rdata_d = 32'(enable_q);
        REG_DROP:    rdata_d = drop_q;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q  <= '0;
      enable_q <= '1;
      drop_q   <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      rrPtr_q  <= rrPtr_d;
      enable_q <= enable_d;
      drop_q   <= drop_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_packet_source_device.sv
module tb_packet_source_device;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_req, mem_we;
  logic [7:0]    mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [CH-1:0] in_valid, in_ready, in_end;
  logic [64*CH-1:0] in_data;
  logic          irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  packet_source_device #(.CHANNELS(CH), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_end    (in_end),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Each bus task starts and ends at a falling edge.
  task automatic busRead(input logic [7:0] addr, output logic [31:0] data);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = addr; mem_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    data = mem_rdata;
    mem_req = 1'b0;
  endtask

  task automatic busWrite(input logic [7:0] addr, input logic [31:0] data);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = addr; mem_wdata = data;
    @(posedge clk);
    @(negedge clk);
    mem_req = 1'b0; mem_we = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    in_valid = '0; in_end = '0; in_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Every channel c sends {0xA5A5000c, 0x0000100c}.
  task automatic setChannelData();
    for (int c = 0; c < CH; c++)
      in_data[c*64 +: 64] = {32'hA5A5_0000 | 32'(c), 32'h0000_1000 | 32'(c)};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 4'hF;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 8'h18;
    @(posedge clk); #1;
    checks++; if (in_ready !== 4'h0) begin errors++; $display("[TB] FAIL reset_ready got=%h exp=0", in_ready); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got=%h exp=0", mem_rdata); end
    doReset();
    busRead(8'h18, rd);
    checks++; if (rd !== 32'hF) begin errors++; $display("[TB] FAIL reset_enable got=%h exp=0000000f", rd); end
    busRead(8'h1C, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_drop got=%h exp=0", rd); end
    busRead(8'h10, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_status got=%h exp=0", rd); end
  endtask

  task automatic test_single_push();
    doReset();
    in_valid = 4'b0001; in_end = 4'b0001;
    in_data[63:0] = 64'h1122_3344_5566_7788;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("[TB] FAIL t1_ready got=%h exp=1", in_ready); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL t1_irq_before got=%b exp=0", irq); end
    @(negedge clk);
    in_valid = '0; in_end = '0;
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL t1_irq got=%b exp=1", irq); end
    busRead(8'h04, rd);
    checks++; if (rd !== 32'h5566_7788) begin errors++; $display("[TB] FAIL t1_lo got=%h exp=55667788", rd); end
    busRead(8'h08, rd);
    checks++; if (rd !== 32'h1122_3344) begin errors++; $display("[TB] FAIL t1_hi got=%h exp=11223344", rd); end
    busRead(8'h0C, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL t1_end got=%h exp=1", rd); end
    busRead(8'h10, rd);
    checks++; if (rd !== 32'h0001_0001) begin errors++; $display("[TB] FAIL t1_status got=%h exp=00010001", rd); end
    busWrite(8'h14, 32'h0);
    busRead(8'h10, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL t1_status_pop got=%h exp=0", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL t1_irq_pop got=%b exp=0", irq); end
  endtask

  task automatic test_round_robin();
    logic [3:0] expReady;
    logic [31:0] expStat;
    doReset();
    setChannelData();
    in_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      expReady = 4'b0001 << (k % 4);
      checks++; if (in_ready !== expReady) begin errors++; $display("[TB] FAIL rr_grant%0d got=%h exp=%h", k, in_ready, expReady); end
      @(negedge clk);
    end
    in_valid = '0;
    for (int k = 0; k < 5; k++) begin
      expStat = {16'(5 - k), 8'(k % 4), 8'h01};
      busRead(8'h10, rd);
      checks++; if (rd !== expStat) begin errors++; $display("[TB] FAIL rr_status%0d got=%h exp=%h", k, rd, expStat); end
      busRead(8'h04, rd);
      checks++; if (rd !== (32'h1000 | 32'(k % 4))) begin errors++; $display("[TB] FAIL rr_data%0d got=%h exp=%h", k, rd, 32'h1000 | 32'(k % 4)); end
      busWrite(8'h14, 32'h0);
    end
  endtask

  task automatic test_full();
    doReset();
    setChannelData();
    in_valid = 4'hF;
    repeat (8) @(negedge clk);
    #1;
    checks++; if (in_ready !== 4'h0) begin errors++; $display("[TB] FAIL full_ready got=%h exp=0", in_ready); end
    busRead(8'h10, rd);
    checks++; if (rd !== 32'h0008_0001) begin errors++; $display("[TB] FAIL full_status got=%h exp=00080001", rd); end
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 8'h14; mem_wdata = '0;
    #1;
    checks++; if (in_ready !== 4'h0) begin errors++; $display("[TB] FAIL full_pop_ready got=%h exp=0", in_ready); end
    @(negedge clk);
    mem_req = 1'b0; mem_we = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("[TB] FAIL full_regrant got=%h exp=1", in_ready); end
    @(negedge clk); #1;
    checks++; if (in_ready !== 4'h0) begin errors++; $display("[TB] FAIL full_refull got=%h exp=0", in_ready); end
    busRead(8'h10, rd);
    checks++; if (rd !== 32'h0008_0101) begin errors++; $display("[TB] FAIL full_status2 got=%h exp=00080101", rd); end
    in_valid = '0;
  endtask

  task automatic test_push_pop();
    doReset();
    in_valid = 4'b0001;
    for (int n = 0; n < 3; n++) begin
      in_data[63:0] = {32'h0, 32'hB000_0000 + 32'(n)};
      @(negedge clk);
    end
    in_data[63:0] = {32'h0, 32'hB000_0003};
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 8'h14; mem_wdata = '0;
    @(negedge clk);
    mem_req = 1'b0; mem_we = 1'b0; in_valid = '0;
    busRead(8'h10, rd);
    checks++; if (rd !== 32'h0003_0001) begin errors++; $display("[TB] FAIL pp_status got=%h exp=00030001", rd); end
    busRead(8'h04, rd);
    checks++; if (rd !== 32'hB000_0001) begin errors++; $display("[TB] FAIL pp_head got=%h exp=b0000001", rd); end
  endtask

  task automatic test_drop_enable();
    doReset();
    busWrite(8'h14, 32'h0);
    busWrite(8'h14, 32'h0);
    busRead(8'h1C, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("[TB] FAIL drop_count got=%h exp=2", rd); end
    busRead(8'h10, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL drop_status got=%h exp=0", rd); end
    busWrite(8'h18, 32'h2);
    busRead(8'h18, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("[TB] FAIL en_read got=%h exp=2", rd); end
    setChannelData();
    in_valid = 4'hF;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (in_ready !== 4'b0010) begin errors++; $display("[TB] FAIL en_grant%0d got=%h exp=2", k, in_ready); end
      @(negedge clk);
    end
    in_valid = '0;
    busRead(8'h10, rd);
    checks++; if (rd !== 32'h0002_0101) begin errors++; $display("[TB] FAIL en_status got=%h exp=00020101", rd); end
  endtask

  task automatic test_reset_mid_burst();
    doReset();
    busWrite(8'h14, 32'h0);
    busRead(8'h1C, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL rst_drop_pre got=%h exp=1", rd); end
    busWrite(8'h18, 32'h3);
    setChannelData();
    in_valid = 4'hF;
    repeat (5) @(negedge clk);
    in_valid = '0;
    busRead(8'h10, rd);
    checks++; if (rd !== 32'h0005_0001) begin errors++; $display("[TB] FAIL rst_status_pre got=%h exp=00050001", rd); end
    in_valid = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 4'h0) begin errors++; $display("[TB] FAIL rst_ready got=%h exp=0", in_ready); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL rst_irq got=%b exp=0", irq); end
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    busRead(8'h10, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rst_status got=%h exp=0", rd); end
    busRead(8'h1C, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rst_drop got=%h exp=0", rd); end
    busRead(8'h18, rd);
    checks++; if (rd !== 32'hF) begin errors++; $display("[TB] FAIL rst_enable got=%h exp=0000000f", rd); end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    in_valid = '0; in_end = '0; in_data = '0;
    test_reset();
    test_single_push();
    test_round_robin();
    test_full();
    test_push_pop();
    test_drop_enable();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
